fir6_stream_ctrl: RTL
=====================

Name: fir6_stream_ctrl

Overview:
- Sequencer between a serial 16-bit sample stream and the 6-parallel FIR datapath (fir ports x6k..x6k_5 / y6k..y6k_5).
- Gathers 6 serial samples into a block, issues the block to the FIR with a one-cycle advance strobe, tracks pipeline latency, and captures result blocks into a 2-block output buffer.
- Re-serialises the result blocks onto a valid/ready output stream.
- Issues a new block only when output buffer space is guaranteed, so backpressure never drops results.

Parameters:
- FIR_LAT, 2, clocks from a fir_en strobe until the matching y6k..y6k_5 block is valid (range 1..8)
- OBUF_BLKS, 2, output buffer depth in 6-sample blocks (fixed 2 in this revision)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_data  in  16  signed input sample
- s_valid  in  1  input sample valid
- s_ready  out  1  controller accepts s_data this cycle
- flush  in  1  one-cycle pulse: zero-pad and issue the partial block
- x6k, x6k_1, x6k_2, x6k_3, x6k_4, x6k_5  out  16 each  block to FIR; offset j of block = j-th accepted sample
- fir_en  out  1  one-cycle strobe; FIR delay lines advance only when fir_en=1
- y6k, y6k_1, y6k_2, y6k_3, y6k_4, y6k_5  in  16 each  FIR result block
- m_data  out  16  signed output sample
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts m_data
- m_last  out  1  marks the final output sample of a flushed block
- busy  out  1  any block gathering, pending, in flight or buffered

Behaviour:
- Reset (async, rst_n=0): all x* = 0, fir_en = 0, m_valid = 0, m_data = 0, m_last = 0, busy = 0, s_ready = 0 during reset; s_ready = 1 the first clock after release. Gather count, credits, latency pipe and buffer all cleared.
- Reset mid-operation discards every partial, in-flight and buffered block. No output follows the reset.
- Gather FSM states: GATHER, PEND, ISSUE.
  - GATHER: s_ready=1. Each s_valid&s_ready writes the sample to slot cnt, then cnt++.
  - When the 6th sample is accepted (cnt 5 to 0), go to PEND. x* hold the block from then until the fir_en cycle inclusive.
  - PEND: s_ready=0. Go to ISSUE when credit is available.
  - ISSUE: fir_en=1 for exactly 1 cycle, then GATHER.
  - If credit is already available when the 6th sample lands, PEND lasts 0 cycles: fir_en asserts the next clock.
- Credit rule: inflight + buffered < OBUF_BLKS. inflight increments on fir_en and decrements on capture. Simultaneous issue and capture leaves inflight unchanged.
- Latency pipe: a FIR_LAT-deep valid shift register, shifted every clock. When its output bit is 1, capture y6k..y6k_5 into the buffer write slot; the write pointer wraps modulo 2. A flush tag travels alongside each valid bit.
- Serialiser: emits y6k first, then y6k_1 up to y6k_5 of the buffer read slot. m_data and m_valid hold stable while m_valid & !m_ready. After the 6th handshake the block is freed, the read pointer wraps, and the next block streams back-to-back with no bubble.
- Flush in GATHER with cnt>0: remaining slots are zero-padded and the FSM goes to PEND. The block carries the flush tag, and m_last=1 on its y6k_5 beat.
  - Flush with cnt=0: ignored.
  - Flush outside GATHER: ignored.
  - Flush together with an accepted sample: the sample is written first, then padding is applied.
- busy = (cnt≠0) | FSM≠GATHER | inflight≠0 | buffered≠0.
- Arithmetic: none on the data path. Samples are passed bit-exact; zero-pad value is 16'sd0.

Optional Feature:
- Macro FIR6_STATS_EN.
- Defined: adds output port blk_cnt[15:0], which increments on each fir_en and wraps 0xFFFF to 0; reset value 0. Also adds output stall_cnt[15:0], which increments on each cycle spent in PEND and saturates at 0xFFFF.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Impulse: FIR_LAT=2; send 1,0,0,0,0,0 with m_ready=1. Required: fir_en exactly 1 cycle after the 6th accept; y captured 2 clocks later; 6 m_data beats equal y6k..y6k_5 in order.
- Throughput: 36 continuous samples 0..35 with m_ready=1. Required: 6 fir_en pulses; x6k_3 of block 2 = 15; output order preserved; no m_valid gap between blocks.
- Backpressure: m_ready=0 while 18 samples are sent. Required: exactly 2 fir_en pulses; s_ready low after the 18th sample; third block held in PEND. On m_ready=1, the third fir_en follows release of the first buffer slot and all 18 outputs arrive.
- Flush: send 7,8,9, then pulse flush. Required: x = 7,8,9,0,0,0; one fir_en; m_last=1 only on the 6th output beat. A flush with cnt=0 produces no fir_en.
- Reset mid-stream: deassert rst_n while one block is in flight and one is buffered. Required: m_valid=0 and busy=0 immediately; no outputs after release; the next 6 inputs form a fresh block.
- FIR6_STATS_EN: run the backpressure case. Required: blk_cnt=3; stall_cnt equals the counted PEND cycles.

Source files
------------

// File: rtl/fir6_stream_ctrl.sv
// Serial-to-6-parallel sequencer for a block FIR: gathers samples, issues blocks on fir_en
// when output space is guaranteed, and re-serialises results. FIR6_STATS_EN adds counters.
module fir6_stream_ctrl #(
    parameter int unsigned FIR_LAT   = 2,
    parameter int unsigned OBUF_BLKS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               flush,
    output logic signed [15:0] x6k,
    output logic signed [15:0] x6k_1,
    output logic signed [15:0] x6k_2,
    output logic signed [15:0] x6k_3,
    output logic signed [15:0] x6k_4,
    output logic signed [15:0] x6k_5,
    output logic               fir_en,
    input  logic signed [15:0] y6k,
    input  logic signed [15:0] y6k_1,
    input  logic signed [15:0] y6k_2,
    input  logic signed [15:0] y6k_3,
    input  logic signed [15:0] y6k_4,
    input  logic signed [15:0] y6k_5,
    output logic signed [15:0] m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               busy
`ifdef FIR6_STATS_EN
    ,
    output logic        [15:0] blk_cnt,
    output logic        [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {StGather, StPend, StIssue} state_t;

    state_t               st;
    logic [2:0]           cnt;
    logic                 blk_flush;
    logic signed [15:0]   xs [6];
    logic signed [15:0]   y_blk [6];
    logic signed [15:0]   obuf [2][6];
    logic [1:0]           obuf_tag;
    logic [3:0]           inflight;
    logic [1:0]           buffered;
    logic [FIR_LAT-1:0]   lat_vld;
    logic [FIR_LAT-1:0]   lat_tag;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [2:0]           beat;

    logic       acc;
    logic [2:0] eff_cnt;
    logic       full;
    logic       flush_go;
    logic [3:0] occ;
    logic       credit;
    logic       cap;
    logic       blk_done;

    assign x6k   = xs[0];
    assign x6k_1 = xs[1];
    assign x6k_2 = xs[2];
    assign x6k_3 = xs[3];
    assign x6k_4 = xs[4];
    assign x6k_5 = xs[5];

    assign y_blk[0] = y6k;
    assign y_blk[1] = y6k_1;
    assign y_blk[2] = y6k_2;
    assign y_blk[3] = y6k_3;
    assign y_blk[4] = y6k_4;
    assign y_blk[5] = y6k_5;

    // A sample landing together with flush counts as gathered before padding.
    assign acc      = s_valid & s_ready;
    assign eff_cnt  = cnt + 3'(acc);
    assign full     = acc && (cnt == 3'd5);
    assign flush_go = flush && (st == StGather) && (eff_cnt != 3'd0);
    assign occ      = inflight + 4'(buffered);
    assign credit   = 32'(occ) < OBUF_BLKS;
    assign cap      = lat_vld[FIR_LAT-1];
    assign blk_done = m_valid && m_ready && (beat == 3'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= StGather;
            s_ready   <= 1'b0;
            fir_en    <= 1'b0;
            cnt       <= '0;
            blk_flush <= 1'b0;
            for (int j = 0; j < 6; j++) xs[j] <= '0;
        end else begin
            fir_en <= 1'b0;
            unique case (st)
                StGather: begin
                    if (acc) xs[cnt] <= s_data;
                    if (full || flush_go) begin
                        for (int j = 0; j < 6; j++) begin
                            if (flush_go && (3'(j) >= eff_cnt)) xs[j] <= '0;
                        end
                        cnt       <= '0;
                        blk_flush <= flush_go;
                        if (credit) begin
                            st      <= StIssue;
                            fir_en  <= 1'b1;
                            s_ready <= 1'b1;
                        end else begin
                            st      <= StPend;
                            s_ready <= 1'b0;
                        end
                    end else begin
                        cnt     <= eff_cnt;
                        s_ready <= 1'b1;
                    end
                end
                StPend: begin
                    if (credit) begin
                        st      <= StIssue;
                        fir_en  <= 1'b1;
                        s_ready <= 1'b1;
                    end
                end
                StIssue: begin
                    // x* only need to hold through this cycle, so slot 0 may refill now.
                    if (acc) begin
                        xs[0] <= s_data;
                        cnt   <= 3'd1;
                    end
                    st      <= StGather;
                    s_ready <= 1'b1;
                end
                default: st <= StGather;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            buffered <= '0;
            lat_vld  <= '0;
            lat_tag  <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            beat     <= '0;
            obuf_tag <= '0;
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 6; j++) obuf[i][j] <= '0;
            end
        end else begin
            inflight <= inflight + 4'(fir_en) - 4'(cap);
            buffered <= buffered + 2'(cap) - 2'(blk_done);
            lat_vld  <= (lat_vld << 1) | FIR_LAT'(fir_en);
            lat_tag  <= (lat_tag << 1) | FIR_LAT'(fir_en & blk_flush);
            if (cap) begin
                obuf[wr_ptr]     <= y_blk;
                obuf_tag[wr_ptr] <= lat_tag[FIR_LAT-1];
                wr_ptr           <= ~wr_ptr;
            end
            if (m_valid && m_ready) begin
                if (beat == 3'd5) begin
                    beat   <= '0;
                    rd_ptr <= ~rd_ptr;
                end else begin
                    beat <= beat + 3'd1;
                end
            end
        end
    end

    always_comb begin
        m_valid = (buffered != 2'd0);
        m_data  = m_valid ? obuf[rd_ptr][beat] : '0;
        m_last  = m_valid && obuf_tag[rd_ptr] && (beat == 3'd5);
    end

    assign busy = (cnt != 3'd0) || (st != StGather) || (inflight != 4'd0) || (buffered != 2'd0);

`ifdef FIR6_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (fir_en) blk_cnt <= blk_cnt + 16'd1;
            if ((st == StPend) && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
